// File: rtl/mod_add_pipe_regs_pkg.sv
// Shared constants, reduction helper and parameter-legality predicates for
// the pipelined modulo adder.
package mod_add_pkg;

  localparam int WARM_CNT_W = 4;

  // Returns {wrap, mod}; raw and modulus are carried at the 33-bit maximum
  // so a single function serves every WIDTH up to 32.
  function automatic logic [33:0] mod_reduce(input logic [32:0] raw,
                                             input logic [32:0] modulus);
    logic        wrap;
    logic [32:0] red;
    wrap = (raw >= modulus);
    red  = wrap ? (raw - modulus) : raw;
    return {wrap, red};
  endfunction

  function automatic bit width_ok(input int width);
    return (width >= 2) && (width <= 32);
  endfunction

  function automatic bit modulus_ok(input int width, input logic [32:0] modulus);
    return (modulus >= 33'd2) && (modulus <= (33'd1 << width));
  endfunction

  function automatic bit warmup_ok(input int warmup);
    return (warmup >= 0) && (warmup < (1 << WARM_CNT_W));
  endfunction

endpackage

// File: rtl/mod_add_pipe_regs_if.sv
// Operand/result handshake bundle for the pipelined modulo adder.
interface mod_add_pipe_regs_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic [WIDTH-1:0] out_mod;
  logic             out_wrap;
  logic             warm_busy;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_mod, out_wrap, warm_busy
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_mod, out_wrap, warm_busy
  );
endinterface

// File: rtl/mod_add_pipe_regs_pipe_slice.sv
// Generic one-entry valid/ready register slice; accepts a new word whenever
// it is empty or its current word is being taken downstream.
module pipe_slice #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data
);
  logic          r_valid;
  logic [DW-1:0] r_data;

  assign o_ready = !r_valid || i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/mod_add_pipe_regs.sv
// Two-stage modulo adder pipeline: S1 holds the operands (B zeroed during
// warm-up), S2 holds the raw sum and its reduction.
module mod_add_pipe_regs
  import mod_add_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter logic [32:0] MODULUS = 33'd1 << WIDTH,
  parameter int          WARMUP  = 2
) (
  input logic                clk,
  input logic                rst,
  mod_add_pipe_regs_if.slave bus
);
  localparam int DW1 = 2 * WIDTH;
  localparam int DW2 = 2 * WIDTH + 2;

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("mod_add_pipe_regs: WIDTH must be within 2..32");
  end
  if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("mod_add_pipe_regs: MODULUS must be within 2..2**WIDTH");
  end
  if (!warmup_ok(WARMUP)) begin : g_bad_warmup
    $error("mod_add_pipe_regs: WARMUP must be within 0..15");
  end

  logic [WARM_CNT_W-1:0] r_warm_cnt;
  logic                  w_s1_ready;
  logic                  w_in_ready;
  logic                  w_in_xfer;
  logic [WIDTH-1:0]      w_b_cap;
  logic                  w_s1_valid;
  logic [DW1-1:0]        w_s1_q;
  logic                  w_s2_ready;
  logic [WIDTH-1:0]      w_a;
  logic [WIDTH-1:0]      w_b;
  logic [WIDTH:0]        w_raw;
  logic [WIDTH-1:0]      w_mod;
  logic                  w_wrap;
  logic [DW2-1:0]        w_s2_q;

  // rst gates in_ready so operands offered during reset are never counted.
  assign w_in_ready = !rst && w_s1_ready;
  assign w_in_xfer  = bus.in_valid && w_in_ready;
  assign w_b_cap    = (r_warm_cnt != '0) ? '0 : bus.in_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_warm_cnt <= WARM_CNT_W'(WARMUP);
    end else if (w_in_xfer && (r_warm_cnt != '0)) begin
      r_warm_cnt <= r_warm_cnt - WARM_CNT_W'(1);
    end
  end

  pipe_slice #(.DW(DW1)) u_s1 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (bus.in_valid),
    .o_ready (w_s1_ready),
    .i_data  ({bus.in_a, w_b_cap}),
    .o_valid (w_s1_valid),
    .i_ready (w_s2_ready),
    .o_data  (w_s1_q)
  );

  assign w_a    = w_s1_q[DW1-1:WIDTH];
  assign w_b    = w_s1_q[WIDTH-1:0];
  assign w_raw  = {1'b0, w_a} + {1'b0, w_b};
  assign w_mod  = WIDTH'(mod_reduce(33'(w_raw), MODULUS));
  assign w_wrap = 1'(mod_reduce(33'(w_raw), MODULUS) >> 33);

  pipe_slice #(.DW(DW2)) u_s2 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_s1_valid),
    .o_ready (w_s2_ready),
    .i_data  ({w_raw, w_mod, w_wrap}),
    .o_valid (bus.out_valid),
    .i_ready (bus.out_ready),
    .o_data  (w_s2_q)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_carry = w_s2_q[DW2-1];
  assign bus.out_sum   = w_s2_q[DW2-2:WIDTH+1];
  assign bus.out_mod   = w_s2_q[WIDTH:1];
  assign bus.out_wrap  = w_s2_q[0];
  assign bus.warm_busy = (r_warm_cnt != '0);
endmodule

// File: tb/tb_mod_add_pipe_regs.sv
// Randomised and directed bench for mod_add_pipe_regs against a queue-based
// behavioural model (WIDTH=8, MODULUS=251, WARMUP=2; plus a 256/0 instance).
module tb_mod_add_pipe_regs;
  localparam int W      = 8;
  localparam int MOD    = 251;
  localparam int WARM   = 2;
  localparam int MOD2   = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mod_add_pipe_regs_if #(.WIDTH(W)) bus1 ();
  mod_add_pipe_regs_if #(.WIDTH(W)) bus2 ();

  mod_add_pipe_regs #(.WIDTH(W), .MODULUS(33'd251), .WARMUP(WARM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  mod_add_pipe_regs #(.WIDTH(W), .MODULUS(33'd256), .WARMUP(0)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: every accepted pair in acceptance order, tagged with its edge.
  typedef struct {
    int acc;
    int a;
    int b;
  } item_t;

  item_t q[$];
  int    ecnt       = 0;
  int    n_acc      = 0;
  bit    live       = 1'b0;
  bit    just_reset = 1'b0;

  always @(negedge clk) begin
    bit    exp_ir;
    bit    exp_ov;
    int    raw;
    int    wrap;
    item_t it;
    exp_ir = !rst && ((q.size() < 2) || bus1.out_ready);
    exp_ov = (q.size() > 0) && (q[0].acc < ecnt);
    if (live) begin
      chk("in_ready", bus1.in_ready, exp_ir);
      chk("out_valid", bus1.out_valid, exp_ov);
      chk("warm_busy", bus1.warm_busy, n_acc < WARM);
      if (exp_ov && bus1.out_valid) begin
        raw  = q[0].a + q[0].b;
        wrap = (raw >= MOD) ? 1 : 0;
        chk("model out_sum", bus1.out_sum, raw % 256);
        chk("model out_carry", bus1.out_carry, raw / 256);
        chk("model out_wrap", bus1.out_wrap, wrap);
        chk("model out_mod", bus1.out_mod, (wrap != 0 ? raw - MOD : raw) % 256);
      end
      if (just_reset) begin
        chk("reset out_sum", bus1.out_sum, 0);
        chk("reset out_mod", bus1.out_mod, 0);
        chk("reset out_carry", bus1.out_carry, 0);
        chk("reset out_wrap", bus1.out_wrap, 0);
      end
    end
    if (rst) begin
      q.delete();
      n_acc      = 0;
      live       = 1'b1;
      just_reset = 1'b1;
    end else begin
      just_reset = 1'b0;
      if (exp_ov && bus1.out_ready) void'(q.pop_front());
      if (bus1.in_valid && exp_ir) begin
        it.acc = ecnt + 1;
        it.a   = int'(bus1.in_a);
        it.b   = (n_acc < WARM) ? 0 : int'(bus1.in_b);
        q.push_back(it);
        n_acc++;
      end
    end
    ecnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input bit v, input int a, input int b);
    bus1.in_valid = v;
    bus1.in_a     = W'(a);
    bus1.in_b     = W'(b);
  endtask

  initial begin
    put(0, 0, 0);
    bus1.out_ready = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.in_a      = '0;
    bus2.in_b      = '0;
    bus2.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;

    // Warm-up zeroing
    put(1, 10, 20);
    @(negedge clk);
    chk("first in_ready", bus1.in_ready, 1);
    chk("first out_valid", bus1.out_valid, 0);
    chk("first warm_busy", bus1.warm_busy, 1);
    cyc(); put(1, 30, 40);
    @(negedge clk);
    chk("warm_busy after 1", bus1.warm_busy, 1);
    cyc(); put(1, 50, 60);
    @(negedge clk);
    chk("w1 out_valid", bus1.out_valid, 1);
    chk("w1 out_mod", bus1.out_mod, 10);
    chk("warm_busy after 2", bus1.warm_busy, 0);
    cyc(); put(0, 0, 0);
    @(negedge clk);
    chk("w2 out_mod", bus1.out_mod, 30);
    cyc();
    @(negedge clk);
    chk("w3 out_mod", bus1.out_mod, 110);
    chk("w3 carry", bus1.out_carry, 0);
    chk("w3 wrap", bus1.out_wrap, 0);
    cyc();
    @(negedge clk);
    chk("w drained", bus1.out_valid, 0);

    // Wrap and carry
    put(1, 200, 100);
    cyc(); put(1, 150, 101);
    cyc(); put(0, 0, 0);
    @(negedge clk);
    chk("c1 out_sum", bus1.out_sum, 44);
    chk("c1 carry", bus1.out_carry, 1);
    chk("c1 out_mod", bus1.out_mod, 49);
    chk("c1 wrap", bus1.out_wrap, 1);
    cyc();
    @(negedge clk);
    chk("c2 out_sum", bus1.out_sum, 251);
    chk("c2 carry", bus1.out_carry, 0);
    chk("c2 out_mod", bus1.out_mod, 0);
    chk("c2 wrap", bus1.out_wrap, 1);
    cyc();

    // Backpressure
    bus1.out_ready = 1'b0;
    put(1, 1, 2);
    cyc(); put(1, 3, 4);
    @(negedge clk);
    chk("bp in_ready one", bus1.in_ready, 1);
    cyc(); put(1, 5, 6);
    @(negedge clk);
    chk("bp in_ready full", bus1.in_ready, 0);
    chk("bp out_mod", bus1.out_mod, 3);
    for (int i = 0; i < 5; i++) begin
      cyc();
      @(negedge clk);
      chk("bp hold in_ready", bus1.in_ready, 0);
      chk("bp hold out_sum", bus1.out_sum, 3);
    end
    cyc();
    bus1.out_ready = 1'b1;
    @(negedge clk);
    chk("bp release in_ready", bus1.in_ready, 1);
    cyc(); put(0, 0, 0);
    @(negedge clk);
    chk("bp r2 out_mod", bus1.out_mod, 7);
    cyc();
    @(negedge clk);
    chk("bp r3 out_mod", bus1.out_mod, 11);
    cyc();
    @(negedge clk);
    chk("bp drained", bus1.out_valid, 0);

    // Warm-up counts transfers, not cycles
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle warm_busy", bus1.warm_busy, 1);
      cyc();
    end
    put(1, 5, 7);
    cyc(); put(0, 0, 0);
    cyc();
    @(negedge clk);
    chk("idle push out_valid", bus1.out_valid, 1);
    chk("idle push out_mod", bus1.out_mod, 5);
    cyc();

    // Reset mid-operation
    bus1.out_ready = 1'b0;
    put(1, 20, 30);
    cyc(); put(1, 40, 50);
    cyc(); put(0, 0, 0);
    @(negedge clk);
    chk("mid full in_ready", bus1.in_ready, 0);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("mid out_valid", bus1.out_valid, 0);
    chk("mid out_sum", bus1.out_sum, 0);
    chk("mid out_mod", bus1.out_mod, 0);
    chk("mid warm_busy", bus1.warm_busy, 1);
    chk("mid in_ready", bus1.in_ready, 1);
    bus1.out_ready = 1'b1;
    put(1, 9, 9);
    cyc(); put(0, 0, 0);
    cyc();
    @(negedge clk);
    chk("mid push out_mod", bus1.out_mod, 9);
    chk("mid push out_sum", bus1.out_sum, 9);
    cyc();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 299) == 0);
      bus1.out_ready = ($urandom_range(0, 3) != 0);
      put($urandom_range(0, 3) != 0,
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(240, 255)) : int'($urandom_range(0, 255)),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(240, 255)) : int'($urandom_range(0, 255)));
      cyc();
    end
    rst = 1'b0;
    put(0, 0, 0);
    bus1.out_ready = 1'b1;
    repeat (4) cyc();

    // Full-range modulus, no warm-up
    @(negedge clk);
    chk("m256 warm_busy", bus2.warm_busy, 0);
    chk("m256 in_ready", bus2.in_ready, 1);
    cyc();
    bus2.in_valid = 1'b1;
    bus2.in_a     = 8'd255;
    bus2.in_b     = 8'd1;
    cyc();
    bus2.in_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("m256 out_valid", bus2.out_valid, 1);
    chk("m256 out_sum", bus2.out_sum, 0);
    chk("m256 carry", bus2.out_carry, 1);
    chk("m256 out_mod", bus2.out_mod, 0);
    chk("m256 wrap", bus2.out_wrap, 1);
    if (MOD2 != 256) chk("m256 config", MOD2, 256);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
